// File: rtl/maxnum_step_counter.sv
// Step counter: latches a maxNum limit on start and counts paced step strobes up to it.
// Latency: done/count==limit appear the cycle after the edge that takes the final step.
// Optional MAXNUM_CNT_RELOAD_EN: restart from 0 on reaching the limit, staying in RUN.
module maxnum_step_counter #(
  parameter int WIDTH    = 5,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             step_en,
  input  logic [WIDTH-1:0] max_num,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Prescaler width; PRESCALE=1 still keeps a 1-bit register that never leaves 0.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] limit, limit_nxt;
  logic [PW-1:0]    pre, pre_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             busy_nxt, done_nxt, err_nxt;
  logic [WIDTH-1:0] count_inc;

  // count never exceeds limit, so count+1 cannot wrap
  assign count_inc = count + WIDTH'(1);

  // State and registered outputs; all outputs are flops so they are glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      limit <= '0;
      pre   <= '0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      limit <= limit_nxt;
      pre   <= pre_nxt;
      count <= count_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
    end
  end

  // Next-state and next-output decode; done/err default low so they only pulse
  always_comb begin
    state_nxt = state;
    limit_nxt = limit;
    pre_nxt   = pre;
    count_nxt = count;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;

    case (state)
      ST_IDLE: begin
        // start together with stop is treated as no request at all
        if (start && !stop) begin
          if (max_num != '0) begin
            limit_nxt = max_num;
            count_nxt = '0;
            pre_nxt   = '0;
            state_nxt = ST_RUN;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (stop) begin
          state_nxt = ST_IDLE;
          count_nxt = '0;
          pre_nxt   = '0;
        end else if (step_en) begin
          if (pre == PS_LAST) begin
            pre_nxt = '0;
            if (count_inc == limit) begin
              done_nxt = 1'b1;
`ifdef MAXNUM_CNT_RELOAD_EN
              count_nxt = '0;
`else
              count_nxt = count_inc;
              state_nxt = ST_DONE;
`endif
            end else begin
              count_nxt = count_inc;
            end
          end else begin
            pre_nxt = pre + PW'(1);
          end
        end
      end

      // One-cycle completion state; inputs are ignored here
      ST_DONE: state_nxt = ST_IDLE;

      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt = (state_nxt == ST_RUN);
  end

endmodule

// File: tb/tb_maxnum_step_counter.sv
// Directed bench for maxnum_step_counter with a PRESCALE=1 and a PRESCALE=4 instance.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Build with MAXNUM_CNT_RELOAD_EN defined to exercise the reload behaviour instead.
module tb_maxnum_step_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start = 1'b0, stop = 1'b0, step_en = 1'b0;
  logic [4:0] max_num = '0;
  logic [4:0] count;
  logic       busy, done, err;

  logic       p_start = 1'b0, p_stop = 1'b0, p_step_en = 1'b0;
  logic [4:0] p_max_num = '0;
  logic [4:0] p_count;
  logic       p_busy, p_done, p_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  maxnum_step_counter #(.WIDTH(5), .PRESCALE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step_en(step_en),
    .max_num(max_num), .count(count), .busy(busy), .done(done), .err(err)
  );

  maxnum_step_counter #(.WIDTH(5), .PRESCALE(4)) dut_ps4 (
    .clk(clk), .rst_n(rst_n), .start(p_start), .stop(p_stop), .step_en(p_step_en),
    .max_num(p_max_num), .count(p_count), .busy(p_busy), .done(p_done), .err(p_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_p_count", p_count, 0);
    rst_n = 1'b1;
    tick();

`ifndef MAXNUM_CNT_RELOAD_EN
    // ---------------- T2: limit 6, continuous steps ----------------
    max_num = 5'd6; start = 1'b1;
    tick();
    start = 1'b0;
    check("t2_busy_after_start", busy, 1);
    check("t2_count_after_start", count, 0);
    max_num = 5'd3;                     // limit is latched; this must be ignored
    step_en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("t2_count_%0d", k), count, k);
      check($sformatf("t2_done_%0d", k), done, (k == 6) ? 1 : 0);
      check($sformatf("t2_busy_%0d", k), busy, (k == 6) ? 0 : 1);
    end
    step_en = 1'b0;
    tick();
    check("t2_done_cleared", done, 0);
    check("t2_count_holds", count, 6);
    check("t2_busy_idle", busy, 0);

    // ---------------- T4: max_num=0 rejected ----------------
    max_num = 5'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_err", err, 1);
    check("t4_busy", busy, 0);
    check("t4_count_unchanged", count, 6);
    tick();
    check("t4_err_pulse_end", err, 0);
    check("t4_busy_still0", busy, 0);

    // ---------------- T3: limit 16, step every other cycle ----------------
    max_num = 5'b10000; start = 1'b1;
    tick();
    start = 1'b0;
    check("t3_busy", busy, 1);
    begin
      int strobes = 0;
      for (int i = 0; i < 32; i++) begin
        step_en = (i % 2 == 0);
        tick();
        if (i % 2 == 0) begin
          strobes++;
          check($sformatf("t3_count_%0d", strobes), count, strobes);
          check($sformatf("t3_done_%0d", strobes), done, (strobes == 16) ? 1 : 0);
        end
      end
    end
    step_en = 1'b0;
    check("t3_done_low_after", done, 0);
    check("t3_count_final", count, 16);

    // ---------------- T5: stop with step_en at count 5 ----------------
    max_num = 5'd11; start = 1'b1;
    tick();
    start = 1'b0;
    step_en = 1'b1;
    repeat (5) tick();
    check("t5_count5", count, 5);
    stop = 1'b1;
    tick();
    stop = 1'b0; step_en = 1'b0;
    check("t5_count_cleared", count, 0);
    check("t5_busy", busy, 0);
    check("t5_no_done", done, 0);
    tick();
    check("t5_no_done_later", done, 0);
    // start and stop in the same cycle: no action
    max_num = 5'd6; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("t5_ss_busy", busy, 0);
    check("t5_ss_err", err, 0);
    tick();
    check("t5_ss_busy_later", busy, 0);

    // ---------------- T1: asynchronous reset mid-RUN ----------------
    max_num = 5'd6; start = 1'b1;
    tick();
    start = 1'b0; step_en = 1'b1;
    repeat (3) tick();
    step_en = 1'b0;
    check("t1_count3", count, 3);
    rst_n = 1'b0;
    #1;
    check("t1_async_count", count, 0);
    check("t1_async_busy", busy, 0);
    check("t1_async_done", done, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t1_post_busy", busy, 0);
    check("t1_post_err", err, 0);

    // ---------------- PRESCALE=4: 24 strobes for limit 6 ----------------
    p_max_num = 5'd6; p_start = 1'b1;
    tick();
    p_start = 1'b0;
    check("ps4_busy", p_busy, 1);
    p_step_en = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      tick();
      check($sformatf("ps4_count_%0d", n), p_count, n / 4);
      check($sformatf("ps4_done_%0d", n), p_done, (n == 24) ? 1 : 0);
    end
    p_step_en = 1'b0;
    check("ps4_busy_end", p_busy, 0);
    tick();
    check("ps4_done_cleared", p_done, 0);
`else
    // ---------------- T6: reload, limit 6, 14 steps ----------------
    max_num = 5'd6; start = 1'b1;
    tick();
    start = 1'b0;
    step_en = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      check($sformatf("t6_count_%0d", k), count, k % 6);
      check($sformatf("t6_done_%0d", k), done, (k % 6 == 0) ? 1 : 0);
      check($sformatf("t6_busy_%0d", k), busy, 1);
    end
    step_en = 1'b0;
    check("t6_final_count", count, 2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t6_stop_busy", busy, 0);
    check("t6_stop_count", count, 0);

    // ---------------- T6 PRESCALE=4: 24 strobes for limit 6 ----------------
    p_max_num = 5'd6; p_start = 1'b1;
    tick();
    p_start = 1'b0;
    p_step_en = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      tick();
      check($sformatf("t6ps4_count_%0d", n), p_count, (n / 4) % 6);
      check($sformatf("t6ps4_done_%0d", n), p_done, (n == 24) ? 1 : 0);
    end
    p_step_en = 1'b0;
    check("t6ps4_busy", p_busy, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
